// File: rtl/kbd_scan_ctrl.sv
// PS/2 scan-code consumer: pops receiver FIFO bytes, decodes make/break/E0/Shift, holds key, ASCII, press count.
// Outputs settle 2 clk after ready is seen in IDLE; at most one pop per 3 clk, never pops while ready=0.
module kbd_scan_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       data,
    input  logic             ready,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic [7:0]       make_code,
    output logic [7:0]       ascii,
    output logic [CNT_W-1:0] count,
    output logic             key_down,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [7:0]       make_code_q, make_code_d;
    logic [7:0]       ascii_q, ascii_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             key_down_q, key_down_d;
    logic             err_q, err_d;
    logic             brk_q, brk_d;
    logic             ext_q, ext_d;
    logic             shift_q, shift_d;

    function automatic logic [7:0] ascii_lut(input logic [7:0] code, input logic sh);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        // Shift only affects letters; digits and controls stay as-is.
        if (sh && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
        return a;
    endfunction

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        nextdata_n_d = nextdata_n_q;
        make_code_d  = make_code_q;
        ascii_d      = ascii_q;
        count_d      = count_q;
        key_down_d   = key_down_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        shift_d      = shift_q;
        err_d        = err_q | overflow;

        case (state_q)
            IDLE: begin
                if (ready) begin
                    byte_d       = data;
                    nextdata_n_d = 1'b0;
                    state_d      = POP;
                end
            end
            POP: begin
                nextdata_n_d = 1'b1;
                state_d      = SETTLE;
                if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (ext_q) begin
                    // Extended keys are swallowed entirely, including their release.
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if ((byte_q == 8'h12) || (byte_q == 8'h59)) begin
                    shift_d = ~brk_q;
                    brk_d   = 1'b0;
                end else if (brk_q) begin
                    brk_d = 1'b0;
                    if (byte_q == make_code_q) begin
                        make_code_d = 8'h00;
                        ascii_d     = 8'h00;
                        key_down_d  = 1'b0;
                    end
                end else if (!(key_down_q && (byte_q == make_code_q))) begin
                    make_code_d = byte_q;
                    ascii_d     = ascii_lut(byte_q, shift_q);
                    key_down_d  = 1'b1;
                    count_d     = count_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                nextdata_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            make_code_q  <= 8'h00;
            ascii_q      <= 8'h00;
            count_q      <= '0;
            key_down_q   <= 1'b0;
            err_q        <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            shift_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_n_q <= nextdata_n_d;
            make_code_q  <= make_code_d;
            ascii_q      <= ascii_d;
            count_q      <= count_d;
            key_down_q   <= key_down_d;
            err_q        <= err_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            shift_q      <= shift_d;
        end
    end

    assign nextdata_n = nextdata_n_q;
    assign make_code  = make_code_q;
    assign ascii      = ascii_q;
    assign count      = count_q;
    assign key_down   = key_down_q;
    assign err        = err_q;

endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Consumer end of the PS/2 keyboard path. Pops scan-code bytes from the PS/2 receiver FIFO using the ready/nextdata_n handshake.
- Decodes make, break (F0) and extended (E0) sequences, and tracks Shift.
- Produces the held key's make code, its ASCII value and a key-press count. These drive the 7-segment display block.

Parameters:
- CNT_W, 8, width of the press counter. It wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock. All logic is clocked on the rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- data  in  8  scan byte at the head of the receiver FIFO. Valid while ready=1.
- ready  in  1  FIFO non-empty.
- overflow  in  1  FIFO overflow flag from the receiver.
- nextdata_n  out  1  pop strobe, active-low, one clk wide.
- make_code  out  8  make code of the currently held key; 0x00 when no key is held.
- ascii  out  8  ASCII value of the held key; 0x00 if no key is held or the key is unmapped.
- count  out  CNT_W  number of accepted key presses.
- key_down  out  1  a counted key is currently held.
- err  out  1  sticky copy of overflow.

Behaviour:
- Reset (clrn=0, asynchronous):
  - outputs: make_code=0, ascii=0, count=0, key_down=0, err=0, nextdata_n=1;
  - internal: brk=0, ext=0, shift=0; FSM goes to IDLE.
- FSM states: IDLE, POP, SETTLE.
  - IDLE: if ready=1, latch data into byte_r, drive nextdata_n=0 next cycle, go to POP.
  - POP: nextdata_n=0 for exactly this cycle; process byte_r; go to SETTLE.
  - SETTLE: nextdata_n=1; wait one cycle for the FIFO head/ready to update; go to IDLE.
  - Throughput: at most 1 byte per 3 clk. Outputs update at the end of the POP cycle (2 clk after ready is seen in IDLE).
- Byte processing in POP, in priority order:
  - 0xE0: set ext=1. No other change.
  - 0xF0: set brk=1. ext is kept.
  - ext=1, any other byte: discard it (extended keys are neither displayed nor counted); clear brk and ext.
  - 0x12 or 0x59 (Shift): shift = ~brk; clear brk. Not counted or displayed.
  - brk=1, byte equals make_code: clear make_code, ascii and key_down; clear brk.
  - brk=1, byte differs from make_code: display unchanged; clear brk.
  - brk=0, key_down=1 and byte equals make_code: typematic repeat. No change, count not incremented.
  - otherwise (new press): make_code=byte, ascii=lookup(byte, shift), key_down=1, count=count+1. A new key pressed while another is held replaces it.
- ASCII lookup, lowercase shown:
  - letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z;
  - digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9';
  - other: 29 → 0x20, 5A → 0x0D; everything else → 0x00.
  - shift=1 maps letters to uppercase (value − 0x20) only.
  - ascii is evaluated at press time; a later Shift change does not alter it.
- count: wraps 2^CNT_W−1 → 0. Increments only on new presses.
- err: set when overflow=1 in any cycle; cleared only by reset.
- clrn asserted mid-sequence (e.g. after E0 or F0): all flags cleared. A following lone code byte is treated as a fresh make.
- ready dropping during POP/SETTLE: no effect. IDLE re-checks ready before the next pop.

Test Plan:
- Reset, then FIFO bytes 1C, F0, 1C → after the 1C pop make_code=0x1C, ascii=0x61, count=1, key_down=1; after the release make_code=0x00, ascii=0x00, count=1. nextdata_n low for exactly 3 single-cycle pulses.
- Bytes 12, 1C, F0, 1C, F0, 12 → ascii=0x41 while held; shift back to 0 at the end; count=1.
- Bytes 24, 24, 24, F0, 24 (typematic) → count=1; make_code=0x24 until the break.
- Bytes E0, 75, E0, F0, 75, then 16 → nothing shown or counted for the extended key; then make_code=0x16, ascii=0x31, count=1.
- Preload count to 0xFF via 255 press/release pairs, then one more press → count=0x00.
- Bytes 1C, F0 then clrn pulse, then 32 → after reset all outputs are 0; then make_code=0x32, ascii=0x62, count=1. Also: overflow=1 for one cycle → err=1 and stays 1.
